// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: buffers {PC, instruction} pairs between IF and ID.
// Registered-only freeze; flush clears the queue and drops the wrong-path word.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`WORD_LEN-1:0] ifPC,
  input  logic [`WORD_LEN-1:0] ifInstruction,
  input  logic                 flush,
  input  logic                 idReady,
  output logic                 freeze,
  output logic                 idValid,
  output logic [`WORD_LEN-1:0] idPC,
  output logic [`WORD_LEN-1:0] idInstruction,
  output logic [CNT_W-1:0]     count
);

  localparam int WL    = `WORD_LEN;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*WL-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [2*WL-1:0]  head;

  assign freeze  = (count_q == CNT_W'(DEPTH));
  assign idValid = (count_q != '0);
  assign push    = ~freeze & ~flush;
  assign pop     = idValid & idReady & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {ifPC, ifInstruction};
  end

  assign head          = idValid ? mem_q[rd_ptr_q] : '0;
  assign idPC          = head[2*WL-1:WL];
  assign idInstruction = head[WL-1:0];
  assign count         = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a simple fetch-stage model.
// Inputs change 1ns after rising edges; outputs are sampled there too.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic [31:0] ifPC;
  logic [31:0] ifInstruction;
  logic        flush;
  logic        idReady;
  logic        freeze;
  logic        idValid;
  logic [31:0] idPC;
  logic [31:0] idInstruction;
  logic [2:0]  count;
  logic [31:0] target;

  int tests;
  int fails;

  if_id_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .ifPC(ifPC),
    .ifInstruction(ifInstruction),
    .flush(flush),
    .idReady(idReady),
    .freeze(freeze),
    .idValid(idValid),
    .idPC(idPC),
    .idInstruction(idInstruction),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  // Fetch model: PC holds while frozen, jumps to target on flush.
  task automatic tick();
    logic fz;
    logic fl;
    fz = freeze;
    fl = flush;
    @(posedge clk);
    #1;
    if (fl) ifPC = target;
    else if (!fz) ifPC = ifPC + 32'd4;
    ifInstruction = ins(ifPC);
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    flush = 1'b0;
    idReady = rdy;
    ifPC = 32'd0;
    ifInstruction = ins(32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    idReady = 1'b0;
    ifPC = 32'd0;
    ifInstruction = ins(32'd0);
    target = 32'd0;
    #12;
    tests++;
    if (count !== 3'd0 || freeze !== 1'b0 || idValid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl count=%0d freeze=%b valid=%b want 0/0/0",
               count, freeze, idValid);
    end
    tests++;
    if (idPC !== 32'd0 || idInstruction !== 32'd0) begin
      fails++;
      $display("FAIL reset_data pc=%h ins=%h want 0/0", idPC, idInstruction);
    end
  endtask

  task automatic test_fill();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (count !== 3'(i + 1)) begin
        fails++;
        $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1);
      end
    end
    tests++;
    if (freeze !== 1'b1 || idPC !== 32'd0 || idInstruction !== ins(32'd0)) begin
      fails++;
      $display("FAIL fill_full freeze=%b pc=%h ins=%h want 1/0/%h",
               freeze, idPC, idInstruction, ins(32'd0));
    end
    tick();
    tests++;
    if (count !== 3'd4 || idPC !== 32'd0 || ifPC !== 32'd16) begin
      fails++;
      $display("FAIL fill_hold count=%0d pc=%h fpc=%h want 4/0/10",
               count, idPC, ifPC);
    end
  endtask

  task automatic test_full_pop();
    idReady = 1'b1;
    tick();
    idReady = 1'b0;
    tests++;
    if (count !== 3'd3 || idPC !== 32'd4 || freeze !== 1'b0) begin
      fails++;
      $display("FAIL full_pop count=%0d pc=%h freeze=%b want 3/4/0",
               count, idPC, freeze);
    end
    tick();
    tests++;
    if (count !== 3'd4 || freeze !== 1'b1 || ifPC !== 32'd20) begin
      fails++;
      $display("FAIL full_refill count=%0d freeze=%b fpc=%h want 4/1/14",
               count, freeze, ifPC);
    end
    // Drain through the remaining entries, including the held 16.
    idReady = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      tests++;
      if (idPC !== 32'(4 * i) || idInstruction !== ins(32'(4 * i))) begin
        fails++;
        $display("FAIL full_drain[%0d] pc=%h want=%h", i, idPC, 4 * i);
      end
    end
    idReady = 1'b0;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (idPC !== 32'(4 * i) || count !== 3'd1 || freeze !== 1'b0) begin
        fails++;
        $display("FAIL stream[%0d] pc=%h count=%0d freeze=%b want %h/1/0",
                 i, idPC, count, freeze, 4 * i);
      end
    end
    idReady = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    tick();
    tick();
    idReady = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (idPC !== 32'(4 * k) || count !== 3'd2) begin
        fails++;
        $display("FAIL wrap[%0d] pc=%h count=%0d want %h/2",
                 k, idPC, count, 4 * k);
      end
    end
    idReady = 1'b0;
  endtask

  task automatic test_flush();
    do_reset(1'b0);
    tick();
    tick();
    tick();
    tests++;
    if (count !== 3'd3 || ifPC !== 32'd12) begin
      fails++;
      $display("FAIL flush_pre count=%0d fpc=%h want 3/c", count, ifPC);
    end
    flush = 1'b1;
    idReady = 1'b1;
    target = 32'h40;
    tick();
    flush = 1'b0;
    idReady = 1'b0;
    tests++;
    if (count !== 3'd0 || idValid !== 1'b0 || idPC !== 32'd0 ||
        freeze !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear count=%0d valid=%b pc=%h freeze=%b want 0",
               count, idValid, idPC, freeze);
    end
    tick();
    tests++;
    if (count !== 3'd1 || idPC !== 32'h40 || idInstruction !== ins(32'h40)) begin
      fails++;
      $display("FAIL flush_target count=%0d pc=%h want 1/40", count, idPC);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    tick();
    tick();
    tick();
    tests++;
    if (count !== 3'd3) begin
      fails++;
      $display("FAIL areset_pre count=%0d want 3", count);
    end
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (count !== 3'd0 || idValid !== 1'b0 || freeze !== 1'b0 ||
        idPC !== 32'd0 || idInstruction !== 32'd0) begin
      fails++;
      $display("FAIL areset count=%0d valid=%b freeze=%b pc=%h ins=%h want 0",
               count, idValid, freeze, idPC, idInstruction);
    end
    do_reset(1'b0);
    tick();
    tests++;
    if (count !== 3'd1 || idPC !== 32'd0) begin
      fails++;
      $display("FAIL areset_after count=%0d pc=%h want 1/0", count, idPC);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill();
    test_full_pop();
    test_stream();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
